udma_i2s_rx_arb: RTL and testbench

Round-robin arbiter and output stage downstream of the I2S receive top. It collects the per-channel 32-bit sample streams (already in the `clk_i` domain after the dual-clock token-ring FIFOs) and merges them into one tagged valid/ready stream toward the uDMA RX channel. It also supports per-channel enable/drain and optional 16-bit sample packing.

---
 rtl/udma_i2s_rx_arb.sv | 117 +++++++++++
 tb/tb_udma_i2s_rx_arb.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udma_i2s_rx_arb.sv
// Round-robin merge of per-channel I2S RX sample streams into one tagged valid/ready stream.
// Define UDMA_I2S_ARB_PACK16_EN to enable per-channel packing of two 16-bit samples per word.
module udma_i2s_rx_arb #(
  parameter int NUM_CHANNELS = 4,
  parameter int CH_W         = $clog2(NUM_CHANNELS)
) (
  input  logic                         clk_i,
  input  logic                         rstn_i,
  input  logic [NUM_CHANNELS-1:0][31:0] in_data_i,
  input  logic [NUM_CHANNELS-1:0]      in_valid_i,
  output logic [NUM_CHANNELS-1:0]      in_ready_o,
  input  logic [NUM_CHANNELS-1:0]      cfg_en_i,
  input  logic [NUM_CHANNELS-1:0]      cfg_pack16_i,
  input  logic                         cfg_clr_i,
  output logic [31:0]                  out_data_o,
  output logic [CH_W-1:0]              out_ch_o,
  output logic                         out_valid_o,
  input  logic                         out_ready_i
);

  localparam logic [CH_W-1:0] LAST_RST = CH_W'(NUM_CHANNELS - 1);

  logic [CH_W-1:0]         last;
  logic [NUM_CHANNELS-1:0] req;
  logic                    found;
  logic                    free;
  logic                    grant_vld;
  logic [CH_W-1:0]         grant;
  logic [CH_W:0]           sum;
  logic                    store_half;
  logic [31:0]             word;

  assign req       = cfg_en_i & in_valid_i;
  assign free      = !out_valid_o || out_ready_i;
  assign grant_vld = found && free && !cfg_clr_i;

  // Search starts just after the last granted channel and wraps modulo NUM_CHANNELS.
  always_comb begin
    grant = last;
    found = 1'b0;
    sum   = '0;
    for (int i = 1; i <= NUM_CHANNELS; i++) begin
      sum = {1'b0, last} + (CH_W+1)'(i);
      if (sum >= (CH_W+1)'(NUM_CHANNELS))
        sum = sum - (CH_W+1)'(NUM_CHANNELS);
      if (!found && req[sum[CH_W-1:0]]) begin
        grant = sum[CH_W-1:0];
        found = 1'b1;
      end
    end
  end

  // Disabled channels are always drained; enabled ones only on their grant.
  always_comb begin
    in_ready_o = ~cfg_en_i;
    if (grant_vld)
      in_ready_o[grant] = 1'b1;
  end

`ifdef UDMA_I2S_ARB_PACK16_EN
  logic [NUM_CHANNELS-1:0][15:0] hold_data;
  logic [NUM_CHANNELS-1:0]       hold_vld;

  assign store_half = cfg_pack16_i[grant] && !hold_vld[grant];
  assign word       = (cfg_pack16_i[grant] && hold_vld[grant]) ?
                      {in_data_i[grant][15:0], hold_data[grant]} : in_data_i[grant];

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      hold_vld <= '0;
    end else if (cfg_clr_i) begin
      hold_vld <= '0;
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (!cfg_en_i[c] || !cfg_pack16_i[c])
          hold_vld[c] <= 1'b0;
        else if (grant_vld && grant == CH_W'(c))
          hold_vld[c] <= !hold_vld[c];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (grant_vld && store_half)
      hold_data[grant] <= in_data_i[grant][15:0];
  end
`else
  logic unused_pack16;

  assign unused_pack16 = ^cfg_pack16_i;
  assign store_half    = 1'b0;
  assign word          = in_data_i[grant];
`endif

  // Output stage: single-entry register, refillable in the same cycle it is popped.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_ch_o    <= '0;
      last        <= LAST_RST;
    end else if (cfg_clr_i) begin
      out_valid_o <= 1'b0;
      last        <= LAST_RST;
    end else if (grant_vld) begin
      last        <= grant;
      out_valid_o <= !store_half;
      if (!store_half) begin
        out_data_o <= word;
        out_ch_o   <= grant;
      end
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_udma_i2s_rx_arb.sv
// Scoreboard bench for udma_i2s_rx_arb; expected tagged words are queued as stimulus is driven.
// Expectations follow UDMA_I2S_ARB_PACK16_EN when it is defined for the build.
module tb_udma_i2s_rx_arb;
  localparam int N  = 4;
  localparam int CW = 2;

  logic                clk = 1'b0;
  logic                rstn;
  logic [N-1:0][31:0]  in_data;
  logic [N-1:0]        in_valid;
  logic [N-1:0]        in_ready;
  logic [N-1:0]        cfg_en;
  logic [N-1:0]        cfg_pack16;
  logic                cfg_clr;
  logic [31:0]         out_data;
  logic [CW-1:0]       out_ch;
  logic                out_valid;
  logic                out_ready;

  int checks = 0;
  int errors = 0;

  logic [31:0] src_q [N][$];
  logic [33:0] exp_q [$];
  logic [33:0] mon_exp;

  udma_i2s_rx_arb #(.NUM_CHANNELS(N)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .cfg_en_i(cfg_en), .cfg_pack16_i(cfg_pack16), .cfg_clr_i(cfg_clr),
    .out_data_o(out_data), .out_ch_o(out_ch), .out_valid_o(out_valid),
    .out_ready_i(out_ready)
  );

  always #5 clk = ~clk;

  // Scoreboard: every accepted output word must match the head of the expected queue.
  always @(negedge clk) begin
    if (rstn && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got ch=%0d data=%h, required no word", out_ch, out_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({out_ch, out_data} !== mon_exp) begin
          errors++;
          $display("FAIL sb_word: got ch=%0d data=%h, required ch=%0d data=%h",
                   out_ch, out_data, mon_exp[33:32], mon_exp[31:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic refresh();
    for (int c = 0; c < N; c++) begin
      in_valid[c] = (src_q[c].size() > 0);
      in_data[c]  = (src_q[c].size() > 0) ? src_q[c][0] : 32'h0;
    end
  endtask

  task automatic src_push(input int c, input logic [31:0] d);
    src_q[c].push_back(d);
    refresh();
  endtask

  task automatic exp_push(input int c, input logic [31:0] d);
    exp_q.push_back({CW'(c), d});
  endtask

  task automatic tick();
    logic [N-1:0] hs;
    @(negedge clk);
    hs = in_valid & in_ready;
    @(posedge clk);
    #1;
    for (int c = 0; c < N; c++)
      if (hs[c] && src_q[c].size() > 0) void'(src_q[c].pop_front());
    refresh();
  endtask

  task automatic pulse_clr();
    cfg_clr = 1'b1;
    tick();
    cfg_clr = 1'b0;
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < bound) begin
      tick();
      n++;
    end
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d words outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; cfg_en = 4'hF; cfg_pack16 = '0; cfg_clr = 1'b0; out_ready = 1'b0;
    refresh();
    #1;
    checks++;
    if ({out_valid, out_data, out_ch} !== 35'h0) begin
      errors++;
      $display("FAIL reset_out: got valid=%b data=%h ch=%0d, required 0/0/0", out_valid, out_data, out_ch);
    end
    checks++;
    if (in_ready !== 4'h0) begin
      errors++;
      $display("FAIL reset_ready_all_en: got %b, required 0000", in_ready);
    end
    cfg_en = 4'b0101;
    #1;
    checks++;
    if (in_ready !== 4'b1010) begin
      errors++;
      $display("FAIL reset_ready_dis: got %b, required 1010", in_ready);
    end
    cfg_en = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    src_push(0, 32'hA5A5_0001);
    exp_push(0, 32'hA5A5_0001);
    tick();
    checks++;
    if ({out_valid, out_ch, out_data} !== {1'b1, 2'd0, 32'hA5A5_0001}) begin
      errors++;
      $display("FAIL single_out: got valid=%b ch=%0d data=%h, required 1/0/a5a50001", out_valid, out_ch, out_data);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_one_cycle: got valid=%b, required 0", out_valid);
    end
    drain(4);
  endtask

  task automatic test_round_robin();
    pulse_clr();
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < N; c++) begin
        src_push(c, {8'(c), 24'(k)});
        exp_push(c, {8'(c), 24'(k)});
      end
    for (int i = 0; i < 2 * N; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_ch !== CW'(i % N)) begin
        errors++;
        $display("FAIL rr_seq[%0d]: got valid=%b ch=%0d, required 1/%0d", i, out_valid, out_ch, i % N);
      end
    end
    drain(4);
  endtask

  task automatic test_back_to_back_stall();
    pulse_clr();
    out_ready = 1'b0;
    src_push(2, 32'h1234_5678);
    exp_push(2, 32'h1234_5678);
    tick();
    src_push(0, 32'h0000_00C0);
    exp_push(0, 32'h0000_00C0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({out_valid, out_ch, out_data} !== {1'b1, 2'd2, 32'h1234_5678} || in_ready !== 4'h0) begin
        errors++;
        $display("FAIL stall[%0d]: got valid=%b ch=%0d data=%h ready=%b, required 1/2/12345678/0000",
                 i, out_valid, out_ch, out_data, in_ready);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0001) begin
      errors++;
      $display("FAIL stall_refill_ready: got %b, required 0001", in_ready);
    end
    tick();
    checks++;
    if ({out_valid, out_ch, out_data} !== {1'b1, 2'd0, 32'h0000_00C0}) begin
      errors++;
      $display("FAIL stall_refill: got valid=%b ch=%0d data=%h, required 1/0/000000c0", out_valid, out_ch, out_data);
    end
    drain(4);
  endtask

  task automatic test_disabled();
    pulse_clr();
    out_ready = 1'b1;
    cfg_en = 4'b1101;
    src_push(1, 32'hDEAD_BEEF);
    src_push(0, 32'h0000_000A);
    src_push(3, 32'h0000_003A);
    exp_push(0, 32'h0000_000A);
    exp_push(3, 32'h0000_003A);
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (in_ready[1] !== 1'b1) begin
        errors++;
        $display("FAIL dis_ready[%0d]: got %b, required 1", i, in_ready[1]);
      end
    end
    checks++;
    if (src_q[1].size() != 0) begin
      errors++;
      $display("FAIL dis_drained: got %0d left, required 0", src_q[1].size());
    end
    drain(4);
    cfg_en = 4'hF;
  endtask

  task automatic test_pack16();
    pulse_clr();
    out_ready = 1'b1;
    cfg_pack16 = 4'b1000;
    src_push(3, 32'hFFFF_1111);
    src_push(3, 32'hFFFF_2222);
`ifdef UDMA_I2S_ARB_PACK16_EN
    exp_push(3, 32'h2222_1111);
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL pack_half: got valid=%b, required 0", out_valid);
    end
    tick();
    checks++;
    if ({out_valid, out_ch, out_data} !== {1'b1, 2'd3, 32'h2222_1111}) begin
      errors++;
      $display("FAIL pack_word: got valid=%b ch=%0d data=%h, required 1/3/22221111", out_valid, out_ch, out_data);
    end
`else
    exp_push(3, 32'hFFFF_1111);
    exp_push(3, 32'hFFFF_2222);
    tick();
    checks++;
    if ({out_valid, out_ch, out_data} !== {1'b1, 2'd3, 32'hFFFF_1111}) begin
      errors++;
      $display("FAIL nopack_word: got valid=%b ch=%0d data=%h, required 1/3/ffff1111", out_valid, out_ch, out_data);
    end
`endif
    drain(4);
    cfg_pack16 = '0;
  endtask

  task automatic test_clear();
    pulse_clr();
    out_ready = 1'b0;
    src_push(1, 32'h0000_0011);
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_ch !== 2'd1) begin
      errors++;
      $display("FAIL clr_pre: got valid=%b ch=%0d, required 1/1", out_valid, out_ch);
    end
    src_push(0, 32'h0000_00C0);
    src_push(2, 32'h0000_00C2);
    exp_push(0, 32'h0000_00C0);
    exp_push(2, 32'h0000_00C2);
    pulse_clr();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL clr_valid: got %b, required 0", out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_ch !== 2'd0) begin
      errors++;
      $display("FAIL clr_next_ch0: got valid=%b ch=%0d, required 1/0", out_valid, out_ch);
    end
    out_ready = 1'b1;
    drain(4);
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    src_push(3, 32'h0000_0033);
    tick();
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid: got valid=%b data=%h, required 0/0", out_valid, out_data);
    end
    src_push(2, 32'h0000_00B2);
    src_push(0, 32'h0000_00B0);
    exp_push(0, 32'h0000_00B0);
    exp_push(2, 32'h0000_00B2);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== 32'h0000_00B0) begin
      errors++;
      $display("FAIL rst_next_ch0: got valid=%b ch=%0d data=%h, required 1/0/000000b0", out_valid, out_ch, out_data);
    end
    drain(4);
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_back_to_back_stall();
    test_disabled();
    test_pack16();
    test_clear();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
